// File: rtl/fetch_unit_if.sv
// Control/decode bundle between the decoder/testbench and the fetch unit.
// The master drives start, branch decode and LUT writes; the slave returns pc, done and cycle_count.
interface fetch_unit_if;
  logic        start;
  logic [9:0]  start_addr;
  logic        halt;
  logic        branch_of;
  logic        branch_no;
  logic        overflow;
  logic [3:0]  target_sel;
  logic        lut_we;
  logic [3:0]  lut_addr;
  logic [9:0]  lut_wdata;
  logic [9:0]  pc;
  logic        done;
  logic [15:0] cycle_count;

  modport master (
    output start, start_addr, halt, branch_of, branch_no, overflow,
           target_sel, lut_we, lut_addr, lut_wdata,
    input  pc, done, cycle_count
  );

  modport slave (
    input  start, start_addr, halt, branch_of, branch_no, overflow,
           target_sel, lut_we, lut_addr, lut_wdata,
    output pc, done, cycle_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Program counter sequencer with IDLE/RUN/HALTED control and a 16-entry branch-target LUT.
// Define FETCH_CYCLE_COUNT_EN to build the saturating executed-cycle counter.
module fetch_unit (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t      state_q, state_d;
  logic [9:0]  pc_q, pc_d;
  logic        done_q, done_d;
  logic [9:0]  lut [16];
  logic        taken;
  logic        start_accept;

  assign taken        = (bus.branch_of & bus.overflow) | (bus.branch_no & ~bus.overflow);
  assign start_accept = bus.start && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE, HALTED: begin
        if (bus.start) begin
          state_d = RUN;
          pc_d    = bus.start_addr;
        end
      end
      RUN: begin
        // Halt wins over any branch decoded in the same instruction.
        if (bus.halt) begin
          state_d = HALTED;
        end else if (taken) begin
          pc_d = lut[bus.target_sel];
        end else begin
          pc_d = pc_q + 10'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_d == HALTED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= 10'h000;
      done_q  <= 1'b0;
      for (int i = 0; i < 16; i++) lut[i] <= 10'h000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      if (bus.lut_we) lut[bus.lut_addr] <= bus.lut_wdata;
    end
  end

`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] count_q;

  // Counts every RUN cycle including the one that decodes HALT; restarts on each accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 16'h0000;
    end else if (start_accept) begin
      count_q <= 16'h0000;
    end else if (state_q == RUN && count_q != 16'hFFFF) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign bus.cycle_count = count_q;
`else
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
  assign bus.cycle_count     = 16'h0000;
`endif

  assign bus.pc   = pc_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit plus hand sequences for the cycle counter.
module tb_fetch_unit;

  logic clk;
  logic reset;
  fetch_unit_if bus ();

  fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FETCH_CYCLE_COUNT_EN
  localparam bit CC_EN = 1'b1;
`else
  localparam bit CC_EN = 1'b0;
`endif

  typedef struct {
    logic       rst;
    logic       start;
    logic [9:0] saddr;
    logic       halt;
    logic       bof;
    logic       bno;
    logic       ov;
    logic [3:0] ts;
    logic       we;
    logic [3:0] waddr;
    logic [9:0] wdata;
    logic [9:0] exp_pc;
    logic       exp_done;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    @(negedge clk);
    reset          = v.rst;
    bus.start      = v.start;
    bus.start_addr = v.saddr;
    bus.halt       = v.halt;
    bus.branch_of  = v.bof;
    bus.branch_no  = v.bno;
    bus.overflow   = v.ov;
    bus.target_sel = v.ts;
    bus.lut_we     = v.we;
    bus.lut_addr   = v.waddr;
    bus.lut_wdata  = v.wdata;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t idle_vec();
    vec_t v;
    v = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 10'h000, 10'h000, 1'b0};
    return v;
  endfunction

  initial begin
    vec_t v;
    int   n;

    reset = 1'b1;
    bus.start = 1'b0; bus.start_addr = '0; bus.halt = 1'b0;
    bus.branch_of = 1'b0; bus.branch_no = 1'b0; bus.overflow = 1'b0;
    bus.target_sel = '0; bus.lut_we = 1'b0; bus.lut_addr = '0; bus.lut_wdata = '0;

    //                rst  st  saddr    hlt bof bno ov  ts    we  wa    wdata    pc       done
    vecs.push_back('{1'b1,1'b0,10'h000,1'b0,1'b0,1'b0,1'b0,4'h0,1'b0,4'h0,10'h000,10'h000,1'b0});
    vecs.push_back('{1'b0,1'b0,10'h000,1'b0,1'b0,1'b0,1'b0,4'h0,1'b0,4'h0,10'h000,10'h000,1'b0});
    vecs.push_back('{1'b0,1'b0,10'h000,1'b1,1'b1,1'b0,1'b1,4'h0,1'b0,4'h0,10'h000,10'h000,1'b0});
    vecs.push_back('{1'b0,1'b0,10'h000,1'b0,1'b0,1'b0,1'b0,4'h0,1'b1,4'h5,10'h100,10'h000,1'b0});
    vecs.push_back('{1'b0,1'b1,10'h020,1'b0,1'b0,1'b0,1'b0,4'h0,1'b0,4'h0,10'h000,10'h020,1'b0});
    vecs.push_back('{1'b0,1'b0,10'h000,1'b0,1'b0,1'b0,1'b0,4'h0,1'b0,4'h0,10'h000,10'h021,1'b0});
    vecs.push_back('{1'b0,1'b1,10'h300,1'b0,1'b0,1'b0,1'b0,4'h0,1'b0,4'h0,10'h000,10'h022,1'b0});
    vecs.push_back('{1'b0,1'b0,10'h000,1'b0,1'b0,1'b0,1'b0,4'h0,1'b0,4'h0,10'h000,10'h023,1'b0});
    vecs.push_back('{1'b0,1'b0,10'h000,1'b0,1'b1,1'b0,1'b1,4'h5,1'b0,4'h0,10'h000,10'h100,1'b0});
    vecs.push_back('{1'b0,1'b0,10'h000,1'b0,1'b1,1'b0,1'b0,4'h5,1'b0,4'h0,10'h000,10'h101,1'b0});
    vecs.push_back('{1'b0,1'b0,10'h000,1'b0,1'b0,1'b1,1'b0,4'h5,1'b0,4'h0,10'h000,10'h100,1'b0});
    vecs.push_back('{1'b0,1'b0,10'h000,1'b0,1'b0,1'b1,1'b1,4'h5,1'b0,4'h0,10'h000,10'h101,1'b0});
    vecs.push_back('{1'b0,1'b0,10'h000,1'b0,1'b1,1'b1,1'b0,4'h5,1'b0,4'h0,10'h000,10'h100,1'b0});
    vecs.push_back('{1'b0,1'b0,10'h000,1'b0,1'b1,1'b0,1'b1,4'h5,1'b1,4'h5,10'h200,10'h100,1'b0});
    vecs.push_back('{1'b0,1'b0,10'h000,1'b0,1'b1,1'b0,1'b1,4'h5,1'b0,4'h0,10'h000,10'h200,1'b0});
    vecs.push_back('{1'b0,1'b0,10'h000,1'b0,1'b0,1'b0,1'b0,4'h0,1'b1,4'h3,10'h040,10'h201,1'b0});
    vecs.push_back('{1'b0,1'b0,10'h000,1'b0,1'b1,1'b0,1'b1,4'h3,1'b0,4'h0,10'h000,10'h040,1'b0});
    vecs.push_back('{1'b0,1'b0,10'h000,1'b1,1'b0,1'b1,1'b0,4'h5,1'b0,4'h0,10'h000,10'h040,1'b1});
    vecs.push_back('{1'b0,1'b0,10'h000,1'b0,1'b0,1'b0,1'b0,4'h0,1'b0,4'h0,10'h000,10'h040,1'b1});
    vecs.push_back('{1'b0,1'b0,10'h000,1'b0,1'b1,1'b0,1'b1,4'h5,1'b0,4'h0,10'h000,10'h040,1'b1});
    vecs.push_back('{1'b0,1'b1,10'h3FE,1'b0,1'b0,1'b0,1'b0,4'h0,1'b0,4'h0,10'h000,10'h3FE,1'b0});
    vecs.push_back('{1'b0,1'b0,10'h000,1'b0,1'b0,1'b0,1'b0,4'h0,1'b0,4'h0,10'h000,10'h3FF,1'b0});
    vecs.push_back('{1'b0,1'b0,10'h000,1'b0,1'b0,1'b0,1'b0,4'h0,1'b0,4'h0,10'h000,10'h000,1'b0});
    vecs.push_back('{1'b0,1'b0,10'h000,1'b0,1'b0,1'b0,1'b0,4'h0,1'b0,4'h0,10'h000,10'h001,1'b0});
    vecs.push_back('{1'b0,1'b0,10'h000,1'b0,1'b0,1'b0,1'b0,4'h0,1'b1,4'h7,10'h055,10'h002,1'b0});
    vecs.push_back('{1'b0,1'b0,10'h000,1'b0,1'b1,1'b0,1'b1,4'h7,1'b0,4'h0,10'h000,10'h055,1'b0});
    vecs.push_back('{1'b1,1'b1,10'h111,1'b1,1'b1,1'b0,1'b1,4'h5,1'b1,4'h6,10'h222,10'h000,1'b0});
    vecs.push_back('{1'b0,1'b0,10'h000,1'b0,1'b1,1'b0,1'b1,4'h5,1'b0,4'h0,10'h000,10'h000,1'b0});
    vecs.push_back('{1'b0,1'b1,10'h010,1'b0,1'b0,1'b0,1'b0,4'h0,1'b0,4'h0,10'h000,10'h010,1'b0});
    vecs.push_back('{1'b0,1'b0,10'h000,1'b0,1'b1,1'b0,1'b1,4'h5,1'b0,4'h0,10'h000,10'h000,1'b0});
    vecs.push_back('{1'b0,1'b0,10'h000,1'b0,1'b1,1'b0,1'b1,4'h6,1'b0,4'h0,10'h000,10'h000,1'b0});
    vecs.push_back('{1'b0,1'b0,10'h000,1'b1,1'b0,1'b0,1'b0,4'h0,1'b0,4'h0,10'h000,10'h000,1'b1});
    vecs.push_back('{1'b1,1'b1,10'h0AA,1'b0,1'b0,1'b0,1'b0,4'h0,1'b0,4'h0,10'h000,10'h000,1'b0});
    vecs.push_back('{1'b0,1'b0,10'h000,1'b0,1'b0,1'b0,1'b0,4'h0,1'b0,4'h0,10'h000,10'h000,1'b0});

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d_pc", i), {6'h0, bus.pc}, {6'h0, vecs[i].exp_pc});
      check_output($sformatf("vec%0d_done", i), {15'h0, bus.done}, {15'h0, vecs[i].exp_done});
    end

    // Cycle counter: start, seven plain RUN cycles, then the halting cycle.
    v = idle_vec(); v.rst = 1'b1;
    apply_stimulus(v);
    check_output("cc_reset", bus.cycle_count, 16'd0);
    v = idle_vec(); v.start = 1'b1; v.saddr = 10'h080;
    apply_stimulus(v);
    check_output("cc_start", bus.cycle_count, 16'd0);
    for (int k = 0; k < 7; k++) apply_stimulus(idle_vec());
    check_output("cc_run7", bus.cycle_count, CC_EN ? 16'd7 : 16'd0);
    check_output("cc_run7_pc", {6'h0, bus.pc}, 16'h0087);
    v = idle_vec(); v.halt = 1'b1;
    apply_stimulus(v);
    n = 0;
    while (!bus.done && n < 4) begin
      apply_stimulus(idle_vec());
      n++;
    end
    check_output("cc_done_seen", {15'h0, bus.done}, 16'd1);
    check_output("cc_halt", bus.cycle_count, CC_EN ? 16'd8 : 16'd0);
    for (int k = 0; k < 3; k++) apply_stimulus(idle_vec());
    check_output("cc_hold", bus.cycle_count, CC_EN ? 16'd8 : 16'd0);
    check_output("cc_hold_pc", {6'h0, bus.pc}, 16'h0087);
    v = idle_vec(); v.start = 1'b1; v.saddr = 10'h000;
    apply_stimulus(v);
    check_output("cc_restart", bus.cycle_count, 16'd0);
    apply_stimulus(idle_vec());
    check_output("cc_restart_run1", bus.cycle_count, CC_EN ? 16'd1 : 16'd0);
    v = idle_vec(); v.rst = 1'b1;
    apply_stimulus(v);
    check_output("cc_mid_reset", bus.cycle_count, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous active-high reset, sampled on rising clk edge.
REQ-003 SHALL have: start  in  1  begin program execution at start_addr.
REQ-004 SHALL have: start_addr  in  10  first instruction address, sampled when start is accepted.
REQ-005 SHALL have: halt  in  1  decoded HALT instruction at current pc.
REQ-006 SHALL have: branch_of  in  1  decoded BOF (branch if ALU overflow flag set).
REQ-007 SHALL have: branch_no  in  1  decoded BNO (branch if ALU overflow flag clear).
REQ-008 SHALL have: overflow  in  1  registered ALU overflow/compare flag.
REQ-009 SHALL have: target_sel  in  4  branch-target LUT index from instruction.
REQ-010 SHALL have: lut_we  in  1; lut_addr  in  4; lut_wdata  in  10  target LUT write port.
REQ-011 SHALL have: pc  out  10  registered instruction ROM address.
REQ-012 SHALL have: done  out  1  high while HALTED.
REQ-013 SHALL have: cycle_count  out  16  executed-cycle counter (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, RUN, HALTED; state, pc, done, cycle_count registered.
REQ-015 IDLE: pc holds, done=0; start=1 -> RUN with pc<=start_addr next edge.
REQ-016 RUN, taken = (branch_of & overflow) | (branch_no & ~overflow); both branch inputs high = unconditional taken.
REQ-017 RUN, halt=1 -> HALTED, pc unchanged, done=1 next edge; halt overrides any branch same cycle.
REQ-018 RUN, taken & ~halt -> pc<=lut[target_sel]; otherwise pc<=pc+1.
REQ-019 pc increment SHALL wrap 10'h3FF -> 10'h000 with no flag.
REQ-020 start during RUN SHALL be ignored.
REQ-021 HALTED: pc frozen, done=1; start=1 -> RUN, pc<=start_addr, done=0 next edge.
REQ-022 Branch/halt inputs SHALL be ignored in IDLE and HALTED.
REQ-023 LUT: 16 x 10-bit, written on rising edge when lut_we=1, any state.
REQ-024 LUT read SHALL be combinational on target_sel; same-cycle write and branch to same entry uses old contents.
REQ-025 Branch latency: pc shows target exactly one edge after the cycle branch condition is sampled.

Reset
REQ-026 reset=1 at edge -> state IDLE, pc=0, done=0, cycle_count=0, all LUT entries=0.
REQ-027 reset SHALL take priority over start, halt, branches and LUT writes, including mid-RUN.

Configuration
REQ-028 Macro FETCH_CYCLE_COUNT_EN SHALL gate the cycle counter.
REQ-029 Defined: cycle_count cleared when start accepted, +1 per RUN cycle (including the halting cycle), saturates at 16'hFFFF, holds in IDLE/HALTED.
REQ-030 Undefined: no counter register; cycle_count tied to 16'h0000; all other behaviour identical.

Verification
REQ-031 reset, start=1 start_addr=10'h020, 3 idle RUN cycles -> pc 0x020,0x021,0x022,0x023; done=0.
REQ-032 lut[5]=0x100 written; RUN, branch_of=1 overflow=1 target_sel=5 -> pc=0x100 next edge; overflow=0 -> pc+1.
REQ-033 branch_no=1 overflow=0 and halt=1 same cycle at pc=0x040 -> HALTED, pc=0x040, done=1.
REQ-034 start_addr=0x3FE, RUN 3 cycles -> pc 0x3FE,0x3FF,0x000,0x001.
REQ-035 reset asserted mid-RUN at pc=0x055 -> next edge pc=0, done=0, IDLE, lut[5]=0.
REQ-036 with FETCH_CYCLE_COUNT_EN: start, 7 RUN cycles then halt -> cycle_count=8 and holds; without macro cycle_count=0 throughout.
